handshake_assert_monitor: RTL and testbench



---
 rtl/handshake_assert_monitor.sv | 189 ++++++++++++++++++
 tb/tb_handshake_assert_monitor.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/handshake_assert_monitor.sv
// Passive valid/ready protocol monitor with sticky first-error capture.
// It only observes its inputs, so it is safe to bind into any design.
//
// state | meaning
// IDLE  | no transfer outstanding on the channel
// PEND  | valid seen without ready; payload snapshot must stay stable
module handshake_assert_monitor #(
  parameter int CHANNELS  = 2,
  parameter int WIDTH     = 8,
  parameter int MAX_STALL = 15,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      CLK,
  input  logic                      ASYNCRESETN,
  input  logic                      en,
  input  logic                      clr,
  input  logic [CHANNELS-1:0]       valid,
  input  logic [CHANNELS-1:0]       ready,
  input  logic [CHANNELS*WIDTH-1:0] data,
  output logic [CHANNELS-1:0]       viol,
  output logic                      error,
  output logic [CW-1:0]             first_chan,
  output logic [1:0]                first_kind,
  output logic [15:0]               err_count
);

  localparam int SW = $clog2(MAX_STALL + 1);
  localparam int PW = $clog2(CHANNELS + 1);
  localparam logic [SW-1:0] STALL_MAX = SW'(MAX_STALL);

  localparam logic [1:0] KIND_NONE = 2'b00;
  localparam logic [1:0] KIND_DROP = 2'b01;
  localparam logic [1:0] KIND_CHG  = 2'b10;
  localparam logic [1:0] KIND_TO   = 2'b11;

  typedef enum logic {IDLE, PEND} state_t;

  logic [CHANNELS-1:0][1:0] chan_kind;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    state_t           state_q, state_d;
    logic [WIDTH-1:0] snap_q, snap_d;
    logic [WIDTH-1:0] cur;
    logic [SW-1:0]    cnt_q, cnt_d;
    logic             fired_q, fired_d;
    logic             stall;
    logic             timeout;
    logic [1:0]       kind;

    assign cur   = data[c*WIDTH +: WIDTH];
    assign stall = valid[c] & ~ready[c];

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) begin
        state_q <= IDLE;
        snap_q  <= '0;
        cnt_q   <= '0;
        fired_q <= 1'b0;
      end else begin
        state_q <= state_d;
        snap_q  <= snap_d;
        cnt_q   <= cnt_d;
        fired_q <= fired_d;
      end
    end

    // The counter parks at MAX_STALL; fired_q remembers that this stall
    // episode already produced its timeout so it is reported only once.
    always_comb begin
      state_d = state_q;
      snap_d  = snap_q;
      cnt_d   = cnt_q;
      fired_d = fired_q;
      timeout = 1'b0;
      kind    = KIND_NONE;
      if (!en) begin
        state_d = IDLE;
        cnt_d   = '0;
        fired_d = 1'b0;
      end else begin
        if (stall) begin
          if (cnt_q == STALL_MAX) begin
            timeout = ~fired_q;
            fired_d = 1'b1;
          end else begin
            cnt_d = cnt_q + SW'(1);
          end
        end else begin
          cnt_d   = '0;
          fired_d = 1'b0;
        end

        case (state_q)
          IDLE: begin
            if (stall) begin
              state_d = PEND;
              snap_d  = cur;
            end
          end
          PEND: begin
            if (!valid[c]) begin
              kind    = KIND_DROP;
              state_d = IDLE;
            end else begin
              if (cur != snap_q) kind = KIND_CHG;
              if (ready[c]) state_d = IDLE;
            end
          end
          default: state_d = IDLE;
        endcase

        if ((kind == KIND_NONE) && timeout) kind = KIND_TO;
      end
    end

    assign chan_kind[c] = kind;
  end

  logic [CHANNELS-1:0] viol_q, viol_d;
  logic                error_q, error_d;
  logic [CW-1:0]       first_chan_q, first_chan_d;
  logic [1:0]          first_kind_q, first_kind_d;
  logic [15:0]         err_count_q, err_count_d;
  logic [PW-1:0]       pop;
  logic [16:0]         sum;
  logic [CW-1:0]       hit_chan;
  logic [1:0]          hit_kind;

  always_comb begin
    viol_d = '0;
    for (int c = 0; c < CHANNELS; c++) viol_d[c] = (chan_kind[c] != KIND_NONE);
    if (!en || clr) viol_d = '0;

    pop = '0;
    for (int c = 0; c < CHANNELS; c++) pop = pop + PW'(viol_d[c]);
    sum = {1'b0, err_count_q} + 17'(pop);

    // Scan downward so the lowest violating channel wins.
    hit_chan = '0;
    hit_kind = KIND_NONE;
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      if (viol_d[c]) begin
        hit_chan = CW'(c);
        hit_kind = chan_kind[c];
      end
    end

    error_d      = error_q;
    first_chan_d = first_chan_q;
    first_kind_d = first_kind_q;
    err_count_d  = err_count_q;
    if (clr) begin
      error_d      = 1'b0;
      first_chan_d = '0;
      first_kind_d = KIND_NONE;
      err_count_d  = '0;
    end else if (|viol_d) begin
      error_d     = 1'b1;
      err_count_d = sum[16] ? 16'hFFFF : sum[15:0];
      if (!error_q) begin
        first_chan_d = hit_chan;
        first_kind_d = hit_kind;
      end
    end
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      viol_q       <= '0;
      error_q      <= 1'b0;
      first_chan_q <= '0;
      first_kind_q <= KIND_NONE;
      err_count_q  <= '0;
    end else begin
      viol_q       <= viol_d;
      error_q      <= error_d;
      first_chan_q <= first_chan_d;
      first_kind_q <= first_kind_d;
      err_count_q  <= err_count_d;
    end
  end

  assign viol       = viol_q;
  assign error      = error_q;
  assign first_chan = first_chan_q;
  assign first_kind = first_kind_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_handshake_assert_monitor.sv
// Bench for handshake_assert_monitor: directed scenarios plus randomized traffic
// checked against a transaction-level reference model.
module tb_handshake_assert_monitor;

  localparam int CH        = 2;
  localparam int W         = 8;
  localparam int MAX_STALL = 3;

  logic        CLK = 1'b0;
  logic        ASYNCRESETN = 1'b1;
  logic        en = 1'b1;
  logic        clr = 1'b0;
  logic [1:0]  valid = '0;
  logic [1:0]  ready = '0;
  logic [15:0] data = '0;
  logic [1:0]  viol;
  logic        error;
  logic        first_chan;
  logic [1:0]  first_kind;
  logic [15:0] err_count;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: a channel is "pending" exactly when its previous enabled
  // sample was a stall; run length is an unbounded consecutive-stall tally.
  logic       m_pend [2];
  logic [7:0] m_snap [2];
  int         m_run  [2];
  logic [1:0] m_viol;
  logic       m_error;
  logic       m_fchan;
  logic [1:0] m_fkind;
  int         m_cnt;

  handshake_assert_monitor #(.CHANNELS(CH), .WIDTH(W), .MAX_STALL(MAX_STALL)) dut (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .en(en), .clr(clr),
    .valid(valid), .ready(ready), .data(data),
    .viol(viol), .error(error), .first_chan(first_chan),
    .first_kind(first_kind), .err_count(err_count)
  );

  always #5 CLK = ~CLK;

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_pend[c] = 1'b0; m_snap[c] = '0; m_run[c] = 0;
    end
    m_viol = '0; m_error = 1'b0; m_fchan = 1'b0; m_fkind = 2'b00; m_cnt = 0;
  endtask

  task automatic model_step();
    logic [1:0] v;
    logic [1:0] k [2];
    logic       s;
    logic [7:0] d;
    int         run_new;
    v = '0;
    for (int c = 0; c < 2; c++) begin
      k[c] = 2'b00;
      s = valid[c] & ~ready[c];
      d = data[c*8 +: 8];
      if (en) begin
        run_new = s ? m_run[c] + 1 : 0;
        if (m_pend[c] && !valid[c]) k[c] = 2'b01;
        else if (m_pend[c] && d != m_snap[c]) k[c] = 2'b10;
        else if (run_new == MAX_STALL + 1) k[c] = 2'b11;
        if (s && !m_pend[c]) m_snap[c] = d;
        m_run[c]  = run_new;
        m_pend[c] = s;
        v[c] = (k[c] != 2'b00) && !clr;
      end else begin
        m_pend[c] = 1'b0;
        m_run[c]  = 0;
      end
    end
    if (clr) begin
      m_error = 1'b0; m_fchan = 1'b0; m_fkind = 2'b00; m_cnt = 0;
    end else if (v != 2'b00) begin
      if (!m_error) begin
        if (v[0]) begin m_fchan = 1'b0; m_fkind = k[0]; end
        else      begin m_fchan = 1'b1; m_fkind = k[1]; end
      end
      m_error = 1'b1;
      m_cnt   = m_cnt + int'(v[0]) + int'(v[1]);
      if (m_cnt > 65535) m_cnt = 65535;
    end
    m_viol = v;
  endtask

  task automatic step();
    @(posedge CLK);
    model_step();
    #1;
  endtask

  task automatic set_ch(input int c, input logic v, input logic r, input logic [7:0] d);
    valid[c] = v;
    ready[c] = r;
    data[c*8 +: 8] = d;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    ASYNCRESETN = 1'b0;
    en = 1'b1; clr = 1'b0; valid = '0; ready = '0; data = '0;
    model_reset();
    #2;
    ASYNCRESETN = 1'b1;
  endtask

  task automatic test_reset();
    #1 ASYNCRESETN = 1'b0;
    model_reset();
    #11;
    vectors++; if (viol !== 2'b00) begin miscompares++; $display("FAIL reset_viol: got %b expected 00", viol); end
    vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL reset_error: got %b expected 0", error); end
    vectors++; if (err_count !== 16'h0) begin miscompares++; $display("FAIL reset_count: got %h expected 0000", err_count); end
    vectors++; if ({first_chan, first_kind} !== 3'b000) begin miscompares++; $display("FAIL reset_first: got %b %b expected 0 00", first_chan, first_kind); end
    ASYNCRESETN = 1'b1;
  endtask

  task automatic test_clean_handshake();
    do_reset();
    set_ch(0, 1, 0, 8'hA5);
    for (int i = 0; i < 2; i++) begin
      step();
      vectors++; if (viol !== 2'b00) begin miscompares++; $display("FAIL clean_stall_viol[%0d]: got %b expected 00", i, viol); end
    end
    set_ch(0, 1, 1, 8'hA5);
    step();
    set_ch(0, 0, 0, 8'h00);
    step();
    vectors++; if (viol !== 2'b00) begin miscompares++; $display("FAIL clean_viol: got %b expected 00", viol); end
    vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL clean_error: got %b expected 0", error); end
    vectors++; if (err_count !== 16'h0) begin miscompares++; $display("FAIL clean_count: got %h expected 0000", err_count); end
  endtask

  task automatic test_valid_drop();
    do_reset();
    set_ch(0, 1, 0, 8'h3C);
    step();
    set_ch(0, 0, 0, 8'h3C);
    step();
    vectors++; if (viol !== 2'b01) begin miscompares++; $display("FAIL drop_viol: got %b expected 01", viol); end
    vectors++; if (error !== 1'b1) begin miscompares++; $display("FAIL drop_error: got %b expected 1", error); end
    vectors++; if ({first_chan, first_kind} !== 3'b001) begin miscompares++; $display("FAIL drop_first: got %b %b expected 0 01", first_chan, first_kind); end
    vectors++; if (err_count !== 16'd1) begin miscompares++; $display("FAIL drop_count: got %0d expected 1", err_count); end
    step();
    vectors++; if (viol !== 2'b00) begin miscompares++; $display("FAIL drop_pulse_len: got %b expected 00", viol); end
    vectors++; if (error !== 1'b1) begin miscompares++; $display("FAIL drop_sticky: got %b expected 1", error); end
  endtask

  task automatic test_data_change();
    do_reset();
    set_ch(1, 1, 0, 8'h10);
    step();
    set_ch(1, 1, 0, 8'h11);
    step();
    vectors++; if (viol !== 2'b10) begin miscompares++; $display("FAIL chg_viol: got %b expected 10", viol); end
    vectors++; if ({first_chan, first_kind} !== 3'b110) begin miscompares++; $display("FAIL chg_first: got %b %b expected 1 10", first_chan, first_kind); end
    set_ch(1, 1, 1, 8'h10);
    set_ch(0, 1, 0, 8'h22);
    step();
    vectors++; if (viol !== 2'b00) begin miscompares++; $display("FAIL chg_complete_viol: got %b expected 00", viol); end
    set_ch(1, 0, 0, 8'h00);
    set_ch(0, 0, 0, 8'h22);
    step();
    vectors++; if (viol !== 2'b01) begin miscompares++; $display("FAIL hold_viol: got %b expected 01", viol); end
    vectors++; if ({first_chan, first_kind} !== 3'b110) begin miscompares++; $display("FAIL hold_first: got %b %b expected 1 10", first_chan, first_kind); end
    vectors++; if (err_count !== 16'd2) begin miscompares++; $display("FAIL hold_count: got %0d expected 2", err_count); end
  endtask

  task automatic test_stall_timeout();
    logic [1:0] exp_v;
    do_reset();
    set_ch(0, 1, 0, 8'h77);
    for (int i = 1; i <= 6; i++) begin
      step();
      exp_v = (i == MAX_STALL + 1) ? 2'b01 : 2'b00;
      vectors++; if (viol !== exp_v) begin miscompares++; $display("FAIL timeout_viol[%0d]: got %b expected %b", i, viol, exp_v); end
    end
    vectors++; if (first_kind !== 2'b11) begin miscompares++; $display("FAIL timeout_kind: got %b expected 11", first_kind); end
    vectors++; if (err_count !== 16'd1) begin miscompares++; $display("FAIL timeout_count: got %0d expected 1", err_count); end
  endtask

  task automatic test_dual_drop_clr();
    do_reset();
    set_ch(0, 1, 0, 8'h01);
    set_ch(1, 1, 0, 8'h02);
    step();
    valid = 2'b00;
    step();
    vectors++; if (viol !== 2'b11) begin miscompares++; $display("FAIL dual_viol: got %b expected 11", viol); end
    vectors++; if ({first_chan, first_kind} !== 3'b001) begin miscompares++; $display("FAIL dual_first: got %b %b expected 0 01", first_chan, first_kind); end
    vectors++; if (err_count !== 16'd2) begin miscompares++; $display("FAIL dual_count: got %0d expected 2", err_count); end
    clr = 1'b1;
    step();
    clr = 1'b0;
    vectors++; if ({viol, error, first_chan, first_kind} !== 6'b0) begin miscompares++; $display("FAIL clr_state: got %b %b %b %b expected all zero", viol, error, first_chan, first_kind); end
    vectors++; if (err_count !== 16'h0) begin miscompares++; $display("FAIL clr_count: got %0d expected 0", err_count); end
    // A violation coinciding with clr is discarded.
    set_ch(0, 1, 0, 8'h05);
    step();
    set_ch(0, 0, 0, 8'h05);
    clr = 1'b1;
    step();
    clr = 1'b0;
    vectors++; if ({viol, error} !== 3'b000) begin miscompares++; $display("FAIL clr_discard: got %b %b expected 00 0", viol, error); end
  endtask

  task automatic test_enable();
    do_reset();
    set_ch(1, 1, 0, 8'h40);
    step();
    set_ch(1, 0, 0, 8'h40);
    step();
    set_ch(0, 1, 0, 8'h50);
    step();
    en = 1'b0;
    step();
    vectors++; if (viol !== 2'b00) begin miscompares++; $display("FAIL en_off_viol: got %b expected 00", viol); end
    en = 1'b1;
    set_ch(0, 0, 0, 8'h50);
    step();
    vectors++; if (viol !== 2'b00) begin miscompares++; $display("FAIL en_idle_viol: got %b expected 00", viol); end
    vectors++; if ({error, first_chan, first_kind} !== 4'b1101) begin miscompares++; $display("FAIL en_hold_first: got %b %b %b expected 1 1 01", error, first_chan, first_kind); end
    vectors++; if (err_count !== 16'd1) begin miscompares++; $display("FAIL en_hold_count: got %0d expected 1", err_count); end
  endtask

  task automatic test_random();
    logic [7:0] d [2];
    do_reset();
    d[0] = 8'h5A; d[1] = 8'h5A;
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < 2; c++) begin
        if ($urandom_range(99) < 15) d[c] = {7'h2D, d[c][0] ^ 1'b1};
        set_ch(c, ($urandom_range(99) < 70), ($urandom_range(99) < 45), d[c]);
      end
      en  = ($urandom_range(99) < 95);
      clr = ($urandom_range(99) < 3);
      step();
      vectors++; if (viol !== m_viol) begin miscompares++; $display("FAIL rand_viol[%0d]: got %b expected %b", i, viol, m_viol); end
      vectors++; if (error !== m_error) begin miscompares++; $display("FAIL rand_error[%0d]: got %b expected %b", i, error, m_error); end
      vectors++; if (first_chan !== m_fchan) begin miscompares++; $display("FAIL rand_fchan[%0d]: got %b expected %b", i, first_chan, m_fchan); end
      vectors++; if (first_kind !== m_fkind) begin miscompares++; $display("FAIL rand_fkind[%0d]: got %b expected %b", i, first_kind, m_fkind); end
      vectors++; if (err_count !== 16'(m_cnt)) begin miscompares++; $display("FAIL rand_count[%0d]: got %0d expected %0d", i, err_count, m_cnt); end
    end
    en = 1'b1;
    clr = 1'b0;
  endtask

  task automatic test_saturate_async_reset();
    do_reset();
    set_ch(0, 1, 0, 8'h00);
    set_ch(1, 1, 0, 8'h00);
    step();
    // Payload now differs from both snapshots: two data-change violations per cycle.
    set_ch(0, 1, 0, 8'h01);
    set_ch(1, 1, 0, 8'h01);
    for (int i = 0; i < 32767; i++) step();
    vectors++; if (err_count !== 16'hFFFE) begin miscompares++; $display("FAIL sat_pre: got %h expected fffe", err_count); end
    step();
    vectors++; if (err_count !== 16'hFFFF) begin miscompares++; $display("FAIL sat_hit: got %h expected ffff", err_count); end
    step();
    vectors++; if (err_count !== 16'hFFFF) begin miscompares++; $display("FAIL sat_hold: got %h expected ffff", err_count); end
    vectors++; if (viol !== 2'b11) begin miscompares++; $display("FAIL sat_viol: got %b expected 11", viol); end
    #2 ASYNCRESETN = 1'b0;
    #1;
    vectors++; if ({viol, error, first_chan, first_kind} !== 6'b0) begin miscompares++; $display("FAIL async_state: got %b %b %b %b expected all zero", viol, error, first_chan, first_kind); end
    vectors++; if (err_count !== 16'h0) begin miscompares++; $display("FAIL async_count: got %h expected 0000", err_count); end
    model_reset();
    #2 ASYNCRESETN = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      vectors++; if ({viol, error} !== 3'b000) begin miscompares++; $display("FAIL post_reset[%0d]: got %b %b expected 00 0", i, viol, error); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_clean_handshake();
    test_valid_drop();
    test_data_change();
    test_stall_timeout();
    test_dual_drop_clr();
    test_enable();
    test_random();
    test_saturate_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
